// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - word-stream loader that assembles AES-128 key/plaintext and gates block valid after a settle time
//
// Collects 32-bit words from a valid/ready stream into a 128-bit key and a
// 128-bit plaintext block, drives them to the combinational AES core, and
// raises blk_valid once the core path has had SETTLE_CYCLES clocks to settle.
// A loaded key is reused for every following block until a new key is streamed.
//
// Ports:
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   in_valid   in   1       in_word valid
//   in_ready   out  1       loader accepts a word this cycle (registered)
//   in_word    in   32      stream word, MSB first
//   in_new_key in   1       with first word of a block: 1 = key+data, 0 = data only
//   data_out   out  128     plaintext, first word in bits [127:96]
//   key_out    out  128     current key, first word in bits [127:96]
//   blk_valid  out  1       outputs settled, core result may be sampled
//   blk_ready  in   1       consumer sampled, release the block
//   key_loaded out  1       a full key has been accepted since reset
//   blk_count  out  CNT_W   released blocks, wrapping
module aes_block_loader #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_word,
    input  logic             in_new_key,
    output logic [127:0]     data_out,
    output logic [127:0]     key_out,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             key_loaded,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic [2:0] {
        IDLE,
        KEY,
        DATA,
        SETTLE,
        OUT
    } state_t;

    // Down-counter starts at SETTLE_CYCLES-1 so OUT is reached exactly
    // SETTLE_CYCLES edges after the last data word is accepted.
    localparam logic [7:0] SETTLE_LOAD = 8'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t     state;
    logic [1:0] cnt;
    logic [7:0] settle_cnt;
    logic       xfer;

    // in_ready is a registered state decode, so this carries no path from
    // in_valid to any output.
    assign xfer = in_valid && in_ready;

    // Word 0 lands in the most-significant 32 bits (bit 0 of the big-endian
    // [0:127] view of the AES block).
    function automatic logic [127:0] put_word(input logic [127:0] v,
                                              input logic [1:0]   idx,
                                              input logic [31:0]  w);
        logic [127:0] r;
        r = v;
        case (idx)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            settle_cnt <= 8'd0;
            data_out   <= '0;
            key_out    <= '0;
            blk_valid  <= 1'b0;
            in_ready   <= 1'b1;
            key_loaded <= 1'b0;
            blk_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        cnt <= 2'd1;
                        if (in_new_key) begin
                            key_out <= put_word(key_out, 2'd0, in_word);
                            state   <= KEY;
                        end else begin
                            data_out <= put_word(data_out, 2'd0, in_word);
                            state    <= DATA;
                        end
                    end
                end

                KEY: begin
                    if (xfer) begin
                        key_out <= put_word(key_out, cnt, in_word);
                        cnt     <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            key_loaded <= 1'b1;
                            state      <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        data_out <= put_word(data_out, cnt, in_word);
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            in_ready <= 1'b0;
                            if (SETTLE_CYCLES == 0) begin
                                blk_valid <= 1'b1;
                                state     <= OUT;
                            end else begin
                                settle_cnt <= SETTLE_LOAD;
                                state      <= SETTLE;
                            end
                        end
                    end
                end

                SETTLE: begin
                    if (settle_cnt == 8'd0) begin
                        blk_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end

                OUT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        blk_count <= blk_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end

                default: begin
                    blk_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// tb/tb_aes_block_loader.sv - self-checking bench for aes_block_loader with a block-level reference model
module tb_aes_block_loader;

    localparam int SV[2]   = '{4, 0};
    localparam int CMOD[2] = '{65536, 16};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]        vld  = '0;
    logic [1:0]        nk   = '0;
    logic [1:0]        brdy = '0;
    logic [1:0][31:0]  wrd  = '0;
    logic [1:0]        ordy, bv, kl;
    logic [1:0][127:0] dout, kout;
    logic [15:0]       cnt_a;
    logic [3:0]        cnt_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    aes_block_loader #(.SETTLE_CYCLES(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(vld[0]), .in_ready(ordy[0]), .in_word(wrd[0]), .in_new_key(nk[0]),
        .data_out(dout[0]), .key_out(kout[0]),
        .blk_valid(bv[0]), .blk_ready(brdy[0]),
        .key_loaded(kl[0]), .blk_count(cnt_a)
    );

    aes_block_loader #(.SETTLE_CYCLES(0), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(vld[1]), .in_ready(ordy[1]), .in_word(wrd[1]), .in_new_key(nk[1]),
        .data_out(dout[1]), .key_out(kout[1]),
        .blk_valid(bv[1]), .blk_ready(brdy[1]),
        .key_loaded(kl[1]), .blk_count(cnt_b)
    );

    // Block-level model: words received so far, whether the block carries a
    // key, remaining settle clocks, and whether a finished block is on offer.
    int          m_got[2];
    bit          m_wk[2];
    int          m_wait[2];
    bit          m_val[2];
    bit          m_kl[2];
    int          m_cnt[2];
    logic [31:0] m_k[2][4];
    logic [31:0] m_d[2][4];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_got[i] = 0; m_wk[i] = 0; m_wait[i] = 0;
                m_val[i] = 0; m_kl[i] = 0; m_cnt[i] = 0;
                for (int j = 0; j < 4; j++) begin
                    m_k[i][j] = '0;
                    m_d[i][j] = '0;
                end
            end else if (m_val[i]) begin
                if (brdy[i]) begin
                    m_val[i] = 0;
                    m_got[i] = 0;
                    m_cnt[i] = (m_cnt[i] + 1) % CMOD[i];
                end
            end else if (m_wait[i] > 0) begin
                m_wait[i]--;
                if (m_wait[i] == 0) m_val[i] = 1;
            end else if (vld[i]) begin
                if (m_got[i] == 0) m_wk[i] = nk[i];
                if (m_wk[i] && m_got[i] < 4) m_k[i][m_got[i]] = wrd[i];
                else m_d[i][m_wk[i] ? m_got[i] - 4 : m_got[i]] = wrd[i];
                m_got[i]++;
                if (m_wk[i] && m_got[i] == 4) m_kl[i] = 1;
                if (m_got[i] == (m_wk[i] ? 8 : 4)) begin
                    if (SV[i] == 0) m_val[i] = 1;
                    else m_wait[i] = SV[i];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d_in_ready", i), 128'(ordy[i]), 128'(!m_val[i] && m_wait[i] == 0));
                chk($sformatf("u%0d_blk_valid", i), 128'(bv[i]), 128'(m_val[i]));
                chk($sformatf("u%0d_key_loaded", i), 128'(kl[i]), 128'(m_kl[i]));
                chk($sformatf("u%0d_data_out", i), dout[i], {m_d[i][0], m_d[i][1], m_d[i][2], m_d[i][3]});
                chk($sformatf("u%0d_key_out", i), kout[i], {m_k[i][0], m_k[i][1], m_k[i][2], m_k[i][3]});
                chk($sformatf("u%0d_blk_count", i), (i == 0) ? 128'(cnt_a) : 128'(cnt_b), 128'(m_cnt[i]));
            end
        end
    end

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] DAT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] DAT2 = 128'hffeeddccbbaa99887766554433221100;

    logic [31:0] kw[4];
    logic [31:0] dw1[4];
    logic [31:0] dw2[4];

    // Present one word and hold it until the unit is ready; the word moves on
    // the next rising edge after this task returns.
    task automatic send(input int i, input logic [31:0] w, input bit k);
        int t;
        @(negedge clk);
        vld[i] = 1'b1; wrd[i] = w; nk[i] = k;
        t = 0;
        while (!ordy[i] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send_timeout", 128'(t < 100), 128'(1));
    endtask

    task automatic send_gap(input int i, input logic [31:0] w, input bit k);
        @(negedge clk);
        vld[i] = 1'b0;
        send(i, w, k);
    endtask

    task automatic wait_blk(input int i, input int exp_lat);
        int t;
        @(negedge clk);
        vld[i] = 1'b0;
        t = 1;
        while (!bv[i] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("u%0d_latency", i), 128'(t - 1), 128'(exp_lat));
    endtask

    task automatic release_blk(input int i);
        @(negedge clk);
        brdy[i] = 1'b1;
        @(negedge clk);
        brdy[i] = 1'b0;
    endtask

    task automatic chk_reset_a(input string nm);
        chk({nm, "_ready"}, 128'(ordy[0]), 128'(1));
        chk({nm, "_valid"}, 128'(bv[0]), 128'(0));
        chk({nm, "_key"}, kout[0], 128'(0));
        chk({nm, "_kl"}, 128'(kl[0]), 128'(0));
        chk({nm, "_cnt"}, 128'(cnt_a), 128'(0));
    endtask

    initial begin
        logic [127:0] snap;
        bit ok;
        for (int j = 0; j < 4; j++) begin
            kw[j]  = KEY1[127 - 32*j -: 32];
            dw1[j] = DAT1[127 - 32*j -: 32];
            dw2[j] = DAT2[127 - 32*j -: 32];
        end

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk_reset_a("reset");
        chk("reset_data", dout[0], 128'(0));
        rst = 1'b0;

        // Vector load with a new key
        for (int j = 0; j < 4; j++) send(0, kw[j], 1'b1);
        for (int j = 0; j < 4; j++) send(0, dw1[j], 1'b0);
        wait_blk(0, 4);
        chk("vec_key", kout[0], KEY1);
        chk("vec_data", dout[0], DAT1);
        chk("vec_kl", 128'(kl[0]), 128'(1));
        release_blk(0);
        chk("vec_release_valid", 128'(bv[0]), 128'(0));
        chk("vec_release_ready", 128'(ordy[0]), 128'(1));
        chk("vec_count", 128'(cnt_a), 128'(1));

        // Key reuse
        for (int j = 0; j < 4; j++) send(0, dw2[j], 1'b0);
        wait_blk(0, 4);
        chk("reuse_key", kout[0], KEY1);
        chk("reuse_data", dout[0], DAT2);
        release_blk(0);
        chk("reuse_count", 128'(cnt_a), 128'(2));

        // Backpressure in OUT while words are offered
        for (int j = 0; j < 4; j++) send(0, $urandom, 1'b0);
        wait_blk(0, 4);
        snap = dout[0];
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vld[0] = 1'b1; wrd[0] = $urandom; brdy[0] = 1'b0;
            if (ordy[0] !== 1'b0 || bv[0] !== 1'b1 || dout[0] !== snap) ok = 1'b0;
        end
        chk("bp_hold", 128'(ok), 128'(1));
        @(negedge clk);
        vld[0] = 1'b0; brdy[0] = 1'b1;
        @(negedge clk);
        brdy[0] = 1'b0;
        chk("bp_release_valid", 128'(bv[0]), 128'(0));
        chk("bp_release_ready", 128'(ordy[0]), 128'(1));
        chk("bp_count", 128'(cnt_a), 128'(3));

        // Stalled word stream
        for (int j = 0; j < 4; j++) send_gap(0, kw[j], 1'b1);
        for (int j = 0; j < 4; j++) send_gap(0, dw1[j], 1'b0);
        wait_blk(0, 4);
        chk("stall_key", kout[0], KEY1);
        chk("stall_data", dout[0], DAT1);
        release_blk(0);

        // Reset after key word 2
        for (int j = 0; j < 3; j++) send(0, kw[j], 1'b1);
        @(negedge clk);
        vld[0] = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_a("rst_key");

        // Reset during SETTLE
        for (int j = 0; j < 4; j++) send(0, kw[j], 1'b1);
        for (int j = 0; j < 4; j++) send(0, dw1[j], 1'b0);
        @(negedge clk);
        vld[0] = 1'b0;
        @(negedge clk);
        chk("settle_valid_low", 128'(bv[0]), 128'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_a("rst_settle");

        // Zero settle time, data-only straight after reset, and count wrap
        for (int j = 0; j < 4; j++) send(1, dw2[j], 1'b0);
        wait_blk(1, 0);
        chk("nokey_key", kout[1], 128'(0));
        chk("nokey_data", dout[1], DAT2);
        chk("nokey_kl", 128'(kl[1]), 128'(0));
        release_blk(1);
        for (int n = 2; n <= 16; n++) begin
            for (int j = 0; j < 4; j++) send(1, $urandom, 1'b0);
            wait_blk(1, 0);
            if (n == 16) chk("wrap_before", 128'(cnt_b), 128'(15));
            release_blk(1);
        end
        chk("wrap_after", 128'(cnt_b), 128'(0));
        for (int j = 0; j < 4; j++) send(1, kw[j], 1'b1);
        for (int j = 0; j < 4; j++) send(1, dw1[j], 1'b0);
        wait_blk(1, 0);
        chk("s0_key", kout[1], KEY1);
        chk("s0_data", dout[1], DAT1);
        release_blk(1);

        // Randomized traffic on both units
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 2; i++) begin
                vld[i]  = ($urandom_range(0, 3) != 0);
                nk[i]   = ($urandom_range(0, 2) == 0);
                wrd[i]  = $urandom;
                brdy[i] = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        rst = 1'b0; vld = '0; brdy = '0;
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
